// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states and fail codes.
package mem_write_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PASS,
        FAIL,
        TIMEOUT
    } chk_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

endpackage

// File: rtl/mwc_table.sv
// Expected-store table: one {addr, data} entry per check, written by the config port,
// read combinationally at the index of the next pending check.
module mwc_table #(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 4,
    localparam int IW        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [2*XLEN-1:0] wr_entry,
    input  logic [IW-1:0]     rd_idx,
    output logic [2*XLEN-1:0] rd_entry
);

    logic [2*XLEN-1:0] entry_vec [NUM_CHECKS];

    // Entries have no reset so a loaded table survives a reset between runs.
    generate
        for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
            logic [2*XLEN-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_idx == IW'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    // Indices past the last entry read as zero instead of falling off the array.
    always_comb begin
        rd_entry = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_entry = entry_vec[i];
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Self-check monitor for the core's store bus: matches stores against an ordered table.
// Optional store/ignore counters are enabled with `define MEM_WRITE_CHECKER_LOG_EN.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              NUM_CHECKS     = 4,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter logic [XLEN-1:0] IGNORE_BASE    = XLEN'(96),
    parameter logic [XLEN-1:0] IGNORE_MASK    = '1,
    localparam int             IW             = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int             CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cfg_we,
    input  logic [IW-1:0]   cfg_idx,
    input  logic [XLEN-1:0] cfg_addr,
    input  logic [XLEN-1:0] cfg_data,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] DataAdr,
    input  logic [XLEN-1:0] WriteData,
    output logic            done,
    output logic            pass,
    output logic [1:0]      fail_code,
    output logic [IW-1:0]   fail_idx,
    output logic [XLEN-1:0] fail_addr,
    output logic [XLEN-1:0] fail_data,
    output logic [IW:0]     progress
`ifdef MEM_WRITE_CHECKER_LOG_EN
    ,
    output logic [31:0]     wr_count,
    output logic [31:0]     ign_count
`endif
);

    localparam logic [CW-1:0] CYCLE_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW:0]   LAST_IDX   = (IW + 1)'(NUM_CHECKS - 1);
    localparam logic [IW:0]   NUM_IDX    = (IW + 1)'(NUM_CHECKS);

    chk_state_t        state_reg;
    logic [CW-1:0]     cycle_reg;
    logic [2*XLEN-1:0] exp_entry;
    logic [XLEN-1:0]   exp_addr;
    logic [XLEN-1:0]   exp_data;
    logic [IW:0]       progress_next;
    logic              cfg_ok;
    logic              hit;
    logic              in_window;
    logic              mismatch;
    logic              last_entry;
    logic              timeout_now;

    assign cfg_ok = cfg_we && (state_reg != RUN) && ({1'b0, cfg_idx} < NUM_IDX);

    mwc_table #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_table (
        .clk      (clk),
        .wr_en    (cfg_ok),
        .wr_idx   (cfg_idx),
        .wr_entry ({cfg_addr, cfg_data}),
        .rd_idx   (progress[IW-1:0]),
        .rd_entry (exp_entry)
    );

    assign {exp_addr, exp_data} = exp_entry;

    // A store that matches the pending entry wins even if it also falls in the window.
    assign hit           = MemWrite && (DataAdr == exp_addr) && (WriteData == exp_data);
    assign in_window     = (DataAdr & IGNORE_MASK) == (IGNORE_BASE & IGNORE_MASK);
    assign mismatch      = MemWrite && !hit && !in_window;
    assign last_entry    = (progress == LAST_IDX);
    assign timeout_now   = (cycle_reg == CYCLE_LAST);
    assign progress_next = progress + 1'b1;

`ifdef MEM_WRITE_CHECKER_LOG_EN
    logic ignored;
    assign ignored = MemWrite && !hit && in_window;
`endif

    always_ff @(posedge clk) begin
        if (reset || (start && (state_reg != RUN))) begin
            state_reg <= reset ? IDLE : RUN;
            cycle_reg <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            fail_idx  <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            progress  <= '0;
`ifdef MEM_WRITE_CHECKER_LOG_EN
            wr_count  <= '0;
            ign_count <= '0;
`endif
        end else if (state_reg == RUN) begin
            // Leaving RUN at CYCLE_LAST keeps the counter at or below TIMEOUT_CYCLES.
            cycle_reg <= cycle_reg + 1'b1;
            if (hit) begin
                progress <= progress_next;
            end
            if (hit && last_entry) begin
                state_reg <= PASS;
                done      <= 1'b1;
                pass      <= 1'b1;
            end else if (mismatch) begin
                state_reg <= FAIL;
                done      <= 1'b1;
                fail_code <= FC_MISMATCH;
                fail_idx  <= progress[IW-1:0];
                fail_addr <= DataAdr;
                fail_data <= WriteData;
            end else if (timeout_now) begin
                state_reg <= TIMEOUT;
                done      <= 1'b1;
                fail_code <= FC_TIMEOUT;
                fail_idx  <= hit ? progress_next[IW-1:0] : progress[IW-1:0];
            end
`ifdef MEM_WRITE_CHECKER_LOG_EN
            if (MemWrite && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (ignored && (ign_count != '1)) begin
                ign_count <= ign_count + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: a run-level reference model predicts each outcome,
// a monitor compares when done rises and while the result is held.
module tb_mem_write_checker;
    localparam int          NC    = 3;
    localparam int          TO    = 20;
    localparam int          IW    = 2;
    localparam logic [31:0] IBASE = 32'd96;
    localparam logic [31:0] IMASK = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset, start, cfg_we, MemWrite;
    logic [IW-1:0] cfg_idx;
    logic [31:0]   cfg_addr, cfg_data, DataAdr, WriteData;
    logic          done, pass;
    logic [1:0]    fail_code;
    logic [IW-1:0] fail_idx;
    logic [31:0]   fail_addr, fail_data;
    logic [IW:0]   progress;
`ifdef MEM_WRITE_CHECKER_LOG_EN
    logic [31:0]   wr_count, ign_count;
`endif

    mem_write_checker #(
        .XLEN(32), .NUM_CHECKS(NC), .TIMEOUT_CYCLES(TO),
        .IGNORE_BASE(IBASE), .IGNORE_MASK(IMASK)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .done(done), .pass(pass), .fail_code(fail_code), .fail_idx(fail_idx),
        .fail_addr(fail_addr), .fail_data(fail_data), .progress(progress)
`ifdef MEM_WRITE_CHECKER_LOG_EN
        , .wr_count(wr_count), .ign_count(ign_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    typedef struct {
        int          pass;
        int          code;
        int          idx;
        logic [31:0] a;
        logic [31:0] d;
        int          prog;
        int          done_cyc;
        int          wr;
        int          ign;
    } exp_t;

    ev_t         ev_q[$];
    exp_t        exp_q[$];
    logic [31:0] tbl_a[NC];
    logic [31:0] tbl_d[NC];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit we, input logic [31:0] a, input logic [31:0] d);
        ev_q.push_back('{we: we, a: a, d: d});
    endtask

    // Walk the run cycle by cycle applying the classification rules; c0 is the cycle
    // on which start is driven, so RUN cycle k is sampled at posedge c0+2+k.
    function automatic exp_t model(input int c0);
        exp_t e;
        ev_t  ev;
        int   pend;
        e    = '{default: 0};
        pend = 0;
        for (int k = 0; k < TO; k++) begin
            if (k < ev_q.size()) ev = ev_q[k];
            else ev = '{we: 1'b0, a: 32'd0, d: 32'd0};
            if (ev.we) begin
                e.wr++;
                if (ev.a == tbl_a[pend] && ev.d == tbl_d[pend]) begin
                    pend++;
                    if (pend == NC) begin
                        e.pass = 1;
                        e.done_cyc = c0 + 2 + k;
                        break;
                    end
                end else if ((ev.a & IMASK) == (IBASE & IMASK)) begin
                    e.ign++;
                end else begin
                    e.code = 1;
                    e.idx = pend;
                    e.a = ev.a;
                    e.d = ev.d;
                    e.done_cyc = c0 + 2 + k;
                    break;
                end
            end
            if (k == TO - 1) begin
                e.code = 2;
                e.idx = pend;
                e.done_cyc = c0 + 2 + k;
            end
        end
        e.prog = pend;
        return e;
    endfunction

    task automatic load_table();
        for (int i = 0; i < NC; i++) begin
            cfg_we = 1'b1;
            cfg_idx = IW'(i);
            cfg_addr = tbl_a[i];
            cfg_data = tbl_d[i];
            tick();
        end
        cfg_idx = IW'(3);
        cfg_addr = $urandom;
        cfg_data = $urandom;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_run();
        exp_t e;
        int   c0;
        int   kt;
        start = 1'b1;
        c0 = cyc;
        e = model(c0);
        exp_q.push_back(e);
        kt = e.done_cyc - c0 - 2;
        tick();
        start = 1'b0;
        for (int k = 0; k <= kt; k++) begin
            if (k < ev_q.size()) begin
                MemWrite = ev_q[k].we;
                DataAdr = ev_q[k].a;
                WriteData = ev_q[k].d;
            end else begin
                MemWrite = 1'b0;
            end
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_idx = IW'($urandom_range(0, NC - 1));
            cfg_addr = $urandom;
            cfg_data = $urandom;
            start = (k == 1);
            tick();
            start = 1'b0;
        end
        cfg_we = 1'b0;
        for (int j = 0; j < NC; j++) begin
            MemWrite = 1'b1;
            DataAdr = tbl_a[j];
            WriteData = tbl_d[j];
            tick();
        end
        MemWrite = 1'b0;
        tick();
        tick();
    endtask

    task automatic fixed_table();
        tbl_a[0] = 32'd100; tbl_d[0] = 32'd25;
        tbl_a[1] = 32'd104; tbl_d[1] = 32'd26;
        tbl_a[2] = 32'd108; tbl_d[2] = 32'd27;
    endtask

    task automatic push_correct();
        for (int i = 0; i < NC; i++) push_ev(1'b1, tbl_a[i], tbl_d[i]);
    endtask

    task automatic gen_random();
        int gp;
        int n;
        int r;
        ev_q.delete();
        gp = 0;
        n = $urandom_range(4, 24);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) push_ev(1'b0, 32'd0, 32'd0);
            else if (r < 65 && gp < NC) begin
                push_ev(1'b1, tbl_a[gp], tbl_d[gp]);
                gp++;
            end else if (r < 90) push_ev(1'b1, IBASE, $urandom);
            else if (r < 95 && gp + 1 < NC) push_ev(1'b1, tbl_a[gp + 1], tbl_d[gp + 1]);
            else push_ev(1'b1, $urandom_range(25, 100) * 4, $urandom);
        end
    endtask

    // Monitor: pop on each rising done, then hold the result against the sticky outputs.
    initial begin
        exp_t cur;
        bit   have;
        logic prev;
        int   runs;
        have = 1'b0;
        prev = 1'b0;
        runs = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: actual=done expected=no run pending");
                end else begin
                    cur = exp_q.pop_front();
                    have = 1'b1;
                    runs++;
                    $display("[TB] run %0d: pass=%0d code=%0d idx=%0d progress=%0d cycle=%0d", runs, pass, fail_code, fail_idx, progress, cyc);
                    chk("done_cycle", cyc, cur.done_cyc);
                    chk("pass", pass, cur.pass);
                    chk("fail_code", fail_code, cur.code);
                    chk("fail_idx", fail_idx, cur.idx);
                    chk("fail_addr", fail_addr, cur.a);
                    chk("fail_data", fail_data, cur.d);
                    chk("progress", progress, cur.prog);
`ifdef MEM_WRITE_CHECKER_LOG_EN
                    chk("wr_count", wr_count, cur.wr);
                    chk("ign_count", ign_count, cur.ign);
`endif
                end
            end else if (done === 1'b1 && have) begin
                chk("sticky_pass", pass, cur.pass);
                chk("sticky_code", fail_code, cur.code);
                chk("sticky_progress", progress, cur.prog);
                chk("sticky_fail_addr", fail_addr, cur.a);
            end
            prev = done;
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_addr = '0; cfg_data = '0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        repeat (3) tick();
        chk("reset_done", done, 0);
        chk("reset_pass", pass, 0);
        chk("reset_fail_code", fail_code, 0);
        chk("reset_fail_idx", fail_idx, 0);
        chk("reset_fail_addr", fail_addr, 0);
        chk("reset_fail_data", fail_data, 0);
        chk("reset_progress", progress, 0);
        reset = 1'b0;
        tick();

        fixed_table();
        load_table();
        // Out-of-order store fails against entry 0.
        ev_q.delete(); push_ev(1'b1, 32'd104, 32'd26); do_run();
        // Correct order with window stores interleaved.
        ev_q.delete(); push_ev(1'b1, IBASE, 32'd7); push_ev(1'b1, IBASE, 32'd9); push_correct(); do_run();
        // Right address, wrong data.
        ev_q.delete(); push_ev(1'b1, 32'd100, 32'd24); do_run();
        // Only ignored stores: timeout 20 cycles after start.
        ev_q.delete();
        for (int i = 0; i < TO; i++) push_ev(i % 2 == 0, IBASE, $urandom);
        do_run();
        // Final match on the timeout cycle wins.
        ev_q.delete(); push_ev(1'b1, tbl_a[0], tbl_d[0]); push_ev(1'b1, tbl_a[1], tbl_d[1]);
        for (int i = 2; i < TO - 1; i++) push_ev(1'b1, IBASE, $urandom);
        push_ev(1'b1, tbl_a[2], tbl_d[2]);
        do_run();
        // Mismatch on the timeout cycle wins.
        ev_q.delete(); push_ev(1'b1, tbl_a[0], tbl_d[0]);
        for (int i = 1; i < TO - 1; i++) push_ev(1'b0, 32'd0, 32'd0);
        push_ev(1'b1, 32'd200, 32'd5);
        do_run();

        // Reset mid-run after one match, then rerun without reloading the table.
        start = 1'b1; tick(); start = 1'b0;
        MemWrite = 1'b1; DataAdr = tbl_a[0]; WriteData = tbl_d[0]; tick();
        MemWrite = 1'b0; tick();
        chk("mid_progress", progress, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midreset_progress", progress, 0);
        chk("midreset_done", done, 0);
        chk("midreset_fail_code", fail_code, 0);
`ifdef MEM_WRITE_CHECKER_LOG_EN
        chk("midreset_wr_count", wr_count, 0);
`endif
        ev_q.delete(); push_correct(); do_run();

        for (int r = 0; r < 40; r++) begin
            if (r % 5 == 0) begin
                for (int i = 0; i < NC; i++) begin
                    tbl_a[i] = $urandom_range(25, 100) * 4;
                    tbl_d[i] = $urandom;
                end
                load_table();
            end
            gen_random();
            do_run();
        end

        repeat (5) tick();
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
